// File: rtl/uart_fifo_pkg.sv
// Constants and edge-detector state encoding shared by the UART receive- and transmit-side FIFOs.
package uart_fifo_pkg;

  localparam int DB_DEF    = 8;
  localparam int AW_DEF    = 2;
  localparam int DEPTH_DEF = 1 << AW_DEF;

  // The registered copy of the input is the state bit.
  typedef enum logic {
    LOW        = 1'b0,
    ARMED_HIGH = 1'b1
  } edge_state_e;

endpackage

// File: rtl/uart_fifo_rx_rise_edge_det.sv
// One-cycle pulse on each low-to-high transition of a level input, no latency, no backpressure.
// Resets armed-high so an input already high when reset is released gives no pulse.
module rise_edge_det
  import uart_fifo_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  edge_state_e r_state;
  edge_state_e w_state_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ARMED_HIGH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    pulse       = 1'b0;
    case (r_state)
      LOW: begin
        if (in) begin
          w_state_nxt = ARMED_HIGH;
          pulse       = 1'b1;
        end
      end
      ARMED_HIGH: begin
        if (!in) w_state_nxt = LOW;
      end
      default: w_state_nxt = ARMED_HIGH;
    endcase
  end

endmodule

// File: rtl/uart_fifo_rx.sv
// UART receive FIFO: edge-triggered push/pop, first-word-fall-through head, drop-on-full (never stalls).
// Optional sticky byte-loss flag enabled by `define UART_FIFO_RX_OVERRUN_EN.
module uart_fifo_rx
  import uart_fifo_pkg::*;
#(
  parameter int DB = DB_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_done,
  input  logic [DB-1:0] d_out,
  input  logic          rd,
  output logic [DB-1:0] r_data,
  output logic          rx_empty,
  output logic          rx_full,
  output logic          overrun
);

  localparam int         DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [DB-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_empty;
  logic          r_full;

  logic          w_push;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic [AW:0]   w_count_nxt;

  rise_edge_det u_push_det (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (rx_done),
    .pulse (w_push)
  );

  rise_edge_det u_pop_det (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (rd),
    .pulse (w_pop)
  );

  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = w_push & (~r_full | w_pop);
  assign w_pop_ok  = w_pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == FULL_CNT);
    end
  end

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst_n && w_push_ok) r_mem[r_wr_ptr] <= d_out;
  end

  assign r_data   = r_mem[r_rd_ptr];
  assign rx_empty = r_empty;
  assign rx_full  = r_full;

`ifdef UART_FIFO_RX_OVERRUN_EN
  logic w_drop;
  logic r_overrun;

  assign w_drop = w_push & r_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n)        r_overrun <= 1'b0;
    else if (w_drop)   r_overrun <= 1'b1;
    else if (w_pop_ok) r_overrun <= 1'b0;
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

endmodule
